rob: RTL and testbench
======================

// Module: rob
// PURPOSE
//  In-order reorder buffer closing the retire loop of the rename stage. Accepts renamed
//  instructions at dispatch, marks them complete on execute writeback, and retires them
//  in program order one per cycle, driving retire_entry_o / retire_entry_o_valid.
//  Rename consumes the retire port to free physical registers; no backpressure is possible.
// PARAMETERS
//  ROBSIZE   16  entries; power of two, >= 2
//  IDX_BITS  $clog2(ROBSIZE)  slot index width (derived, not overridable)
// PORTS
//  clk                   in   1           clock
//  rst                   in   1           synchronous reset, active-high
//  alloc_i               in   rob_entry_t entry from rename (id, pc, rd, prd, needprf2arf)
//  alloc_i_valid         in   1           dispatch request
//  alloc_i_ready         out  1           ROB not full
//  alloc_idx_o           out  IDX_BITS    slot given to alloc_i (tail index)
//  wb_i_valid            in   1           execute completion
//  wb_idx_i              in   IDX_BITS    slot completing
//  wb_fault_i            in   1           completion raised an exception
//  retire_entry_o        out  rob_entry_t entry retiring (done/fault fields set)
//  retire_entry_o_valid  out  1           one-cycle pulse per retired entry
//  flush_o               out  1           pulses with a faulting retire
//  count_o               out  IDX_BITS+1  occupied entries
// BEHAVIOUR
//  Reset: head=tail=0, all slot busy/done/fault=0; count_o=0, alloc_i_ready=1,
//   retire_entry_o_valid=0, flush_o=0, retire_entry_o=0. Reset mid-operation drops all entries.
//  Pointers: head/tail are IDX_BITS+1 wide (wrap bit). empty: head==tail; full: index bits
//   equal, wrap bits differ. count_o = tail-head (modulo 2^(IDX_BITS+1)).
//  Allocate: fire = alloc_i_valid && alloc_i_ready. On fire, slot[tail] <= alloc_i, busy=1,
//   done=0, fault=0; tail++. alloc_idx_o = tail[IDX_BITS-1:0] combinationally.
//  alloc_i_ready = !full from registered state only; no same-cycle retire bypass.
//  Writeback: wb_i_valid sets done=1, fault=wb_fault_i on slot wb_idx_i at the edge.
//   Writeback to a non-busy slot is ignored and flagged by a simulation assertion.
//  Retire: combinational pick when slot[head].busy && slot[head].done; at the edge
//   retire_entry_o <= slot[head], retire_entry_o_valid <= 1, busy cleared, head++.
//   Output is registered: writeback in cycle N -> done at N+1 -> retire pulse visible in N+2.
//   At most one retire per cycle; non-done head blocks all younger done entries.
//  Fault: if retiring head has fault=1: pulse flush_o with the retire, clear all busy bits,
//   set tail <= head+1 (ROB empty next cycle). Same-cycle alloc fire is discarded (tail
//   override wins); same-cycle writebacks are discarded.
//  Simultaneous alloc + retire: both apply; count unchanged. Alloc into full ROB impossible.
//  Simultaneous alloc + writeback to the tail slot: illegal (slot not busy yet), ignored.
//  Wrap-around: indices wrap mod ROBSIZE; wrap bit toggles; no special casing otherwise.
//  retire_entry_o.needprf2arf/prd pass through unchanged from alloc_i.
// STRUCTURE
//  Package C gains: ROBSIZE, ROB_IDX_BITS, rob_id_t, rob_entry_t {id, pc, rd, prd,
//   needprf2arf, done, fault}. Rename consumes the same rob_entry_t.
//  Single module; payload array plus packed busy/done/fault vectors; no sub-module.
// TESTING
//  1 Reset then alloc 3 (ids 0,1,2), wb idx 2,1,0 in cycles 5,6,7 -> retires ids 0,1,2 in
//    cycles 9,10,11, strictly in order; count_o 3->0.
//  2 Alloc 16 with no wb -> alloc_i_ready=0 after 16th, count_o=16; wb idx 0 -> retire id 0
//    two cycles later, alloc_i_ready=1 the cycle after retire.
//  3 Steady state: alloc + wb + retire every cycle for 40 entries -> indices wrap twice,
//    retire ids consecutive, count_o constant.
//  4 Alloc 5, wb idx1 fault=1, idx0 ok -> retire id 0, then id 1 with flush_o=1;
//    next cycle count_o=0, ids 2..4 never retire; alloc in flush cycle dropped.
//  5 Assert rst with 7 entries busy and a wb in flight -> next cycle count_o=0,
//    retire_entry_o_valid=0, alloc_idx_o=0.
//  6 wb to non-busy slot 9 while empty -> no state change, assertion fires.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer and the rename stage that feeds it.
//   ROBSIZE       number of ROB slots (power of two, >= 2)
//   ROB_IDX_BITS  slot index width
//   rob_id_t      program-order instruction id carried through the ROB
//   rob_entry_t   payload allocated by rename and handed back on retire;
//                 done/fault are filled in by the ROB on the retire port
package rob_pkg;

    localparam int ROBSIZE      = 16;
    localparam int ROB_IDX_BITS = $clog2(ROBSIZE);

    typedef logic [7:0] rob_id_t;

    typedef struct packed {
        rob_id_t     id;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [5:0]  prd;
        logic        needprf2arf;
        logic        done;
        logic        fault;
    } rob_entry_t;

endpackage

// File: rtl/rob.sv
// In-order reorder buffer. Rename allocates at the tail, execute marks slots
// complete by index, and the head retires in program order, one entry per
// cycle, on a registered one-cycle pulse. A faulting retire flushes the ROB.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   alloc_i / _valid      entry from rename and dispatch request
//   alloc_i_ready         ROB not full (registered state only)
//   alloc_idx_o           slot that alloc_i lands in (tail index)
//   wb_i_valid, wb_idx_i  completion of slot wb_idx_i
//   wb_fault_i            that completion raised an exception
//   retire_entry_o/_valid retiring entry with done/fault set; one-cycle pulse
//   flush_o               pulses together with a faulting retire
//   count_o               occupied entries
module rob #(
    parameter  int ROBSIZE  = rob_pkg::ROBSIZE,
    localparam int IDX_BITS = $clog2(ROBSIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  rob_pkg::rob_entry_t alloc_i,
    input  logic                alloc_i_valid,
    output logic                alloc_i_ready,
    output logic [IDX_BITS-1:0] alloc_idx_o,
    input  logic                wb_i_valid,
    input  logic [IDX_BITS-1:0] wb_idx_i,
    input  logic                wb_fault_i,
    output rob_pkg::rob_entry_t retire_entry_o,
    output logic                retire_entry_o_valid,
    output logic                flush_o,
    output logic [IDX_BITS:0]   count_o
);
    import rob_pkg::*;

    localparam logic [IDX_BITS:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [IDX_BITS:0]   head_q, head_d;
    logic [IDX_BITS:0]   tail_q, tail_d;
    logic [ROBSIZE-1:0]  busy_q, busy_d;
    logic [ROBSIZE-1:0]  done_q, done_d;
    logic [ROBSIZE-1:0]  fault_q, fault_d;
    rob_entry_t          retire_q, retire_d;
    logic                retire_valid_q, retire_valid_d;
    logic                flush_q, flush_d;

    rob_entry_t          slot_q [ROBSIZE];

    logic [IDX_BITS-1:0] head_idx;
    logic [IDX_BITS-1:0] tail_idx;
    logic                full;
    logic                alloc_fire;
    logic                retire_fire;
    logic                retire_fault;
    logic                slot_we;

    assign head_idx = head_q[IDX_BITS-1:0];
    assign tail_idx = tail_q[IDX_BITS-1:0];

    // Empty is head == tail; full is same index with opposite wrap bits.
    assign full = (head_idx == tail_idx) && (head_q[IDX_BITS] != tail_q[IDX_BITS]);

    assign alloc_i_ready = !full;
    assign alloc_fire    = alloc_i_valid && alloc_i_ready;
    assign retire_fire   = busy_q[head_idx] && done_q[head_idx];
    assign retire_fault  = retire_fire && fault_q[head_idx];
    // A flush wipes the allocation made in the same cycle, so skip its write.
    assign slot_we       = alloc_fire && !retire_fault;

    always_comb begin
        // NOTE: every variable gets a default before any branch so the block
        // cannot infer a latch on paths that leave it unassigned.
        head_d         = head_q;
        tail_d         = tail_q;
        busy_d         = busy_q;
        done_d         = done_q;
        fault_d        = fault_q;
        retire_d       = retire_q;
        retire_valid_d = 1'b0;
        flush_d        = 1'b0;

        if (alloc_fire) begin
            busy_d[tail_idx]  = 1'b1;
            done_d[tail_idx]  = 1'b0;
            fault_d[tail_idx] = 1'b0;
            tail_d            = tail_q + PTR_ONE;
        end

        // The tail slot is not busy until after this edge, so a same-cycle
        // writeback to it falls under the idle-slot rule and is dropped.
        if (wb_i_valid && busy_q[wb_idx_i]) begin
            done_d[wb_idx_i]  = 1'b1;
            fault_d[wb_idx_i] = wb_fault_i;
        end

        if (retire_fire) begin
            retire_d         = slot_q[head_idx];
            retire_d.done    = 1'b1;
            retire_d.fault   = fault_q[head_idx];
            retire_valid_d   = 1'b1;
            busy_d[head_idx] = 1'b0;
            head_d           = head_q + PTR_ONE;
        end

        // Faulting retire empties the ROB. The tail override beats the
        // same-cycle allocation and the cleared vectors beat any writeback.
        if (retire_fault) begin
            busy_d  = '0;
            done_d  = '0;
            fault_d = '0;
            tail_d  = head_q + PTR_ONE;
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            fault_q        <= '0;
            retire_q       <= '0;
            retire_valid_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            fault_q        <= fault_d;
            retire_q       <= retire_d;
            retire_valid_q <= retire_valid_d;
            flush_q        <= flush_d;
        end
    end

    // NOTE: the payload array has no reset; a slot is only read once its busy
    // bit is set, and busy is reset, so stale payload is never observed.
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slot_q[tail_idx] <= alloc_i;
        end
    end

    assign alloc_idx_o          = tail_idx;
    assign retire_entry_o       = retire_q;
    assign retire_entry_o_valid = retire_valid_q;
    assign flush_o              = flush_q;
    assign count_o              = tail_q - head_q;

    // A writeback to an idle slot indicates an upstream bookkeeping bug; the
    // hardware drops it, the simulation flags it.
    wb_to_idle_slot : assert property (@(posedge clk) disable iff (rst)
        wb_i_valid |-> busy_q[wb_idx_i])
        else $warning("rob: writeback to idle slot %0d ignored", wb_idx_i);

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: in-order retire, full condition,
// steady-state wrap-around, fault flush, mid-operation reset, idle writeback.
module tb_rob;
    import rob_pkg::*;

    logic             clk;
    logic             rst;
    rob_entry_t       alloc_i;
    logic             alloc_i_valid;
    logic             alloc_i_ready;
    logic [3:0]       alloc_idx_o;
    logic             wb_i_valid;
    logic [3:0]       wb_idx_i;
    logic             wb_fault_i;
    rob_entry_t       retire_entry_o;
    logic             retire_entry_o_valid;
    logic             flush_o;
    logic [4:0]       count_o;

    int vectors     = 0;
    int miscompares = 0;

    rob dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_i              (alloc_i),
        .alloc_i_valid        (alloc_i_valid),
        .alloc_i_ready        (alloc_i_ready),
        .alloc_idx_o          (alloc_idx_o),
        .wb_i_valid           (wb_i_valid),
        .wb_idx_i             (wb_idx_i),
        .wb_fault_i           (wb_fault_i),
        .retire_entry_o       (retire_entry_o),
        .retire_entry_o_valid (retire_entry_o_valid),
        .flush_o              (flush_o),
        .count_o              (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Payload derived from the id so every field of a retired entry is checkable.
    function automatic rob_entry_t mk(input int n);
        rob_entry_t e;
        e             = '0;
        e.id          = rob_id_t'(n);
        e.pc          = 32'h0000_1000 + 32'(n * 4);
        e.rd          = 5'(n);
        e.prd         = 6'(n) ^ 6'h2A;
        e.needprf2arf = n[0];
        return e;
    endfunction

    function automatic rob_entry_t exp_ret(input int n, input logic f);
        rob_entry_t e;
        e       = mk(n);
        e.done  = 1'b1;
        e.fault = f;
        return e;
    endfunction

    // Inputs change #1 after the edge; outputs are read #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_i_valid = 1'b0;
        alloc_i       = '0;
        wb_i_valid    = 1'b0;
        wb_idx_i      = '0;
        wb_fault_i    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (count_o !== 5'd0) begin $display("FAIL rst_count: got %0d want 0", count_o); miscompares++; end
        vectors++;
        if (alloc_i_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", alloc_i_ready); miscompares++; end
        vectors++;
        if (retire_entry_o_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", retire_entry_o_valid); miscompares++; end
        vectors++;
        if (flush_o !== 1'b0) begin $display("FAIL rst_flush: got %b want 0", flush_o); miscompares++; end
        vectors++;
        if (retire_entry_o !== rob_entry_t'(0)) begin $display("FAIL rst_entry: got %h want 0", retire_entry_o); miscompares++; end
        vectors++;
        if (alloc_idx_o !== 4'd0) begin $display("FAIL rst_idx: got %0d want 0", alloc_idx_o); miscompares++; end
        vectors++;
    endtask

    // Out-of-order writebacks must still retire in allocation order.
    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_i       = mk(i);
            alloc_i_valid = 1'b1;
            if (alloc_idx_o !== 4'(i)) begin $display("FAIL t1_idx%0d: got %0d want %0d", i, alloc_idx_o, i); miscompares++; end
            vectors++;
            step();
        end
        idle();
        if (count_o !== 5'd3) begin $display("FAIL t1_count3: got %0d want 3", count_o); miscompares++; end
        vectors++;
        step();
        for (int j = 0; j < 3; j++) begin
            wb_i_valid = 1'b1;
            wb_idx_i   = 4'(2 - j);
            step();
            if (retire_entry_o_valid !== 1'b0) begin $display("FAIL t1_early%0d: got valid %b want 0", j, retire_entry_o_valid); miscompares++; end
            vectors++;
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(k, 1'b0)) begin
                $display("FAIL t1_ret%0d: got v=%b %h want v=1 %h", k, retire_entry_o_valid, retire_entry_o, exp_ret(k, 1'b0));
                miscompares++;
            end
            vectors++;
            if (count_o !== 5'(2 - k)) begin $display("FAIL t1_cnt%0d: got %0d want %0d", k, count_o, 2 - k); miscompares++; end
            vectors++;
        end
        step();
        if (retire_entry_o_valid !== 1'b0) begin $display("FAIL t1_after: got valid %b want 0", retire_entry_o_valid); miscompares++; end
        vectors++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (alloc_i_ready !== 1'b1) begin $display("FAIL t2_ready%0d: got %b want 1", i, alloc_i_ready); miscompares++; end
            vectors++;
            alloc_i       = mk(i);
            alloc_i_valid = 1'b1;
            step();
        end
        idle();
        if (alloc_i_ready !== 1'b0) begin $display("FAIL t2_full_ready: got %b want 0", alloc_i_ready); miscompares++; end
        vectors++;
        if (count_o !== 5'd16) begin $display("FAIL t2_count16: got %0d want 16", count_o); miscompares++; end
        vectors++;
        // A dispatch request while full must not fire.
        alloc_i       = mk(99);
        alloc_i_valid = 1'b1;
        step();
        idle();
        if (count_o !== 5'd16) begin $display("FAIL t2_nofire: got %0d want 16", count_o); miscompares++; end
        vectors++;
        wb_i_valid = 1'b1;
        wb_idx_i   = 4'd0;
        step();
        idle();
        if (retire_entry_o_valid !== 1'b0 || alloc_i_ready !== 1'b0) begin
            $display("FAIL t2_wbcycle: got v=%b rdy=%b want v=0 rdy=0", retire_entry_o_valid, alloc_i_ready);
            miscompares++;
        end
        vectors++;
        step();
        if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(0, 1'b0)) begin
            $display("FAIL t2_ret0: got v=%b %h want v=1 %h", retire_entry_o_valid, retire_entry_o, exp_ret(0, 1'b0));
            miscompares++;
        end
        vectors++;
        if (alloc_i_ready !== 1'b1 || count_o !== 5'd15) begin
            $display("FAIL t2_free: got rdy=%b cnt=%0d want rdy=1 cnt=15", alloc_i_ready, count_o);
            miscompares++;
        end
        vectors++;
    endtask

    // Step k allocates entry k and writes back entry k-1; entry k-2 retires.
    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 42; k++) begin
            if (k < 40) begin
                alloc_i       = mk(k);
                alloc_i_valid = 1'b1;
                if (alloc_idx_o !== 4'(k % 16)) begin $display("FAIL t3_idx%0d: got %0d want %0d", k, alloc_idx_o, k % 16); miscompares++; end
                vectors++;
            end else begin
                alloc_i_valid = 1'b0;
            end
            wb_i_valid = (k >= 1 && k <= 40);
            wb_idx_i   = 4'((k + 15) % 16);
            step();
            if (k >= 2) begin
                if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(k - 2, 1'b0)) begin
                    $display("FAIL t3_ret%0d: got v=%b %h want v=1 %h", k - 2, retire_entry_o_valid, retire_entry_o, exp_ret(k - 2, 1'b0));
                    miscompares++;
                end
            end else if (retire_entry_o_valid !== 1'b0) begin
                $display("FAIL t3_fill%0d: got valid %b want 0", k, retire_entry_o_valid);
                miscompares++;
            end
            vectors++;
            if (k >= 1 && k <= 39) begin
                if (count_o !== 5'd2) begin $display("FAIL t3_cnt%0d: got %0d want 2", k, count_o); miscompares++; end
                vectors++;
            end
        end
        idle();
        if (count_o !== 5'd0) begin $display("FAIL t3_drain: got %0d want 0", count_o); miscompares++; end
        vectors++;
    endtask

    task automatic test_fault_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_i       = mk(i);
            alloc_i_valid = 1'b1;
            step();
        end
        idle();
        wb_i_valid = 1'b1;
        wb_idx_i   = 4'd1;
        wb_fault_i = 1'b1;
        step();
        wb_idx_i   = 4'd0;
        wb_fault_i = 1'b0;
        step();
        idle();
        step();
        if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(0, 1'b0) || flush_o !== 1'b0) begin
            $display("FAIL t4_ret0: got v=%b fl=%b %h want v=1 fl=0 %h", retire_entry_o_valid, flush_o, retire_entry_o, exp_ret(0, 1'b0));
            miscompares++;
        end
        vectors++;
        // Flush cycle: this allocation and writeback must both be discarded.
        alloc_i       = mk(50);
        alloc_i_valid = 1'b1;
        wb_i_valid    = 1'b1;
        wb_idx_i      = 4'd2;
        step();
        idle();
        if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(1, 1'b1) || flush_o !== 1'b1) begin
            $display("FAIL t4_ret1: got v=%b fl=%b %h want v=1 fl=1 %h", retire_entry_o_valid, flush_o, retire_entry_o, exp_ret(1, 1'b1));
            miscompares++;
        end
        vectors++;
        if (count_o !== 5'd0 || alloc_idx_o !== 4'd2) begin
            $display("FAIL t4_empty: got cnt=%0d idx=%0d want cnt=0 idx=2", count_o, alloc_idx_o);
            miscompares++;
        end
        vectors++;
        for (int s = 0; s < 3; s++) begin
            step();
            if (retire_entry_o_valid !== 1'b0 || flush_o !== 1'b0) begin
                $display("FAIL t4_quiet%0d: got v=%b fl=%b want v=0 fl=0", s, retire_entry_o_valid, flush_o);
                miscompares++;
            end
            vectors++;
        end
        alloc_i       = mk(60);
        alloc_i_valid = 1'b1;
        step();
        idle();
        wb_i_valid = 1'b1;
        wb_idx_i   = 4'd2;
        step();
        idle();
        step();
        if (retire_entry_o_valid !== 1'b1 || retire_entry_o !== exp_ret(60, 1'b0)) begin
            $display("FAIL t4_resume: got v=%b %h want v=1 %h", retire_entry_o_valid, retire_entry_o, exp_ret(60, 1'b0));
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_midop_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            alloc_i       = mk(i);
            alloc_i_valid = 1'b1;
            step();
        end
        idle();
        wb_i_valid = 1'b1;
        wb_idx_i   = 4'd0;
        step();
        rst           = 1'b1;
        wb_idx_i      = 4'd3;
        alloc_i       = mk(77);
        alloc_i_valid = 1'b1;
        step();
        rst = 1'b0;
        idle();
        if (count_o !== 5'd0 || retire_entry_o_valid !== 1'b0 || alloc_idx_o !== 4'd0) begin
            $display("FAIL t5_reset: got cnt=%0d v=%b idx=%0d want cnt=0 v=0 idx=0", count_o, retire_entry_o_valid, alloc_idx_o);
            miscompares++;
        end
        vectors++;
        step();
        step();
        if (retire_entry_o_valid !== 1'b0 || count_o !== 5'd0) begin
            $display("FAIL t5_after: got v=%b cnt=%0d want v=0 cnt=0", retire_entry_o_valid, count_o);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_idle_wb();
        idle();
        wb_i_valid = 1'b1;
        wb_idx_i   = 4'd9;
        step();
        idle();
        if (count_o !== 5'd0 || alloc_idx_o !== 4'd0 || alloc_i_ready !== 1'b1) begin
            $display("FAIL t6_state: got cnt=%0d idx=%0d rdy=%b want cnt=0 idx=0 rdy=1", count_o, alloc_idx_o, alloc_i_ready);
            miscompares++;
        end
        vectors++;
        step();
        step();
        if (retire_entry_o_valid !== 1'b0 || flush_o !== 1'b0) begin
            $display("FAIL t6_noretire: got v=%b fl=%b want v=0 fl=0", retire_entry_o_valid, flush_o);
            miscompares++;
        end
        vectors++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_full();
        test_back_to_back();
        test_fault_flush();
        test_midop_reset();
        test_idle_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
